// File: rtl/gmm_score_sequencer.sv
// gmm_score_sequencer: walks every (Gaussian, dimension) pair and feeds operands plus latency-matched tags to the score pipeline.
// Define SCORE_SEQ_STALL_CNT_EN to add the stall_cycles hold counter port.
module gmm_score_sequencer #(
  parameter int NUM_DIM   = 39,
  parameter int NUM_GAUSS = 8,
  parameter int SCORE_LAT = 20,
  parameter int DIM_AW    = 6,
  parameter int PAR_AW    = 9,
  parameter int GAUSS_W   = 3
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic [DIM_AW-1:0]  feat_addr,
  input  logic [31:0]        feat_data,
  output logic [PAR_AW-1:0]  param_addr,
  input  logic [31:0]        mean_data,
  input  logic [31:0]        prec_data,
  output logic [31:0]        feature,
  output logic [31:0]        mean,
  output logic [31:0]        prec,
  output logic               logd_valid,
  output logic               logd_last,
  output logic [GAUSS_W-1:0] logd_gauss
`ifdef SCORE_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);
  localparam int S = SCORE_LAT + 2;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2;
  logic [1:0] state;
  logic [GAUSS_W-1:0] g;
  logic [S-1:0] tv, tl;
  logic [GAUSS_W-1:0] tg [S];
  logic issue, d_end, g_end, fin;
  assign issue = state == ISSUE && !hold;
  assign d_end = feat_addr == DIM_AW'(NUM_DIM - 1);
  assign g_end = g == GAUSS_W'(NUM_GAUSS - 1);
  // Only the final result is left in the tag line once draining finishes.
  assign fin = state == DRAIN && tv == (S'(1) << (S - 1));
  assign logd_valid = tv[S-1];
  assign logd_last = tl[S-1];
  assign logd_gauss = tg[S-1];
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      feat_addr <= '0;
      param_addr <= '0;
      g <= '0;
      tv <= '0;
      tl <= '0;
      for (int k = 0; k < S; k++) tg[k] <= '0;
      feature <= '0;
      mean <= '0;
      prec <= '0;
    end else begin
      done <= fin;
      if (state == IDLE && start) begin
        state <= ISSUE;
        busy <= 1'b1;
        feat_addr <= '0;
        param_addr <= '0;
        g <= '0;
      end else if (issue) begin
        feat_addr <= d_end ? '0 : feat_addr + DIM_AW'(1);
        param_addr <= param_addr + PAR_AW'(1);
        g <= d_end ? g + GAUSS_W'(1) : g;
        state <= d_end && g_end ? DRAIN : ISSUE;
      end else if (fin) begin
        state <= IDLE;
        busy <= 1'b0;
      end
      tv <= {tv[S-2:0], issue};
      tl <= {tl[S-2:0], issue && d_end};
      tg[0] <= issue ? g : '0;
      for (int k = 1; k < S; k++) tg[k] <= tg[k-1];
      // tv[0] marks the cycle the memories return data for an issued pair.
      feature <= tv[0] ? feat_data : '0;
      mean <= tv[0] ? mean_data : '0;
      prec <= tv[0] ? prec_data : '0;
    end
  end
`ifdef SCORE_SEQ_STALL_CNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) stall_cycles <= '0;
    else if (state == IDLE && start) stall_cycles <= '0;
    else if (state == ISSUE && hold && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule
